div_radix2: RTL and testbench
=============================

# div_radix2

Multi-cycle radix-2 restoring divider in the execute stage. It answers the divider start/done handshake that the hazard unit uses to stall the pipeline: `divstall = start & ~done`. It accepts signed or unsigned DIV/DIVU operands and returns remainder and quotient for the HI/LO write. It holds its result across global stalls and abandons work on an execute-stage flush.

## Interface
Parameters:
- `WIDTH`, 32: operand width. The iteration count equals `WIDTH`.

Ports:
- `clk` in 1: single clock. Everything is sampled on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: the execute-stage instruction is a divide (`divstartE`). Held high while that instruction sits in E.
- `signed_div` in 1: 1 = DIV, 0 = DIVU. Sampled with `start`.
- `a` in WIDTH: dividend. Sampled with `start`.
- `b` in WIDTH: divisor. Sampled with `start`.
- `cancel` in 1: execute-stage flush or exception (`flushE`).
- `stall_hold` in 1: global memory stall (`all_stall`). E is frozen while this is high.
- `done` out 1: result valid (`divdoneE`).
- `result` out 2*WIDTH: {remainder, quotient}, i.e. {HI, LO}.

## Operation
- States: IDLE, BUSY, DONE. Reset puts the block in IDLE with `done`=0, `result`=0, counter=0.
- IDLE:
  - `start & ~cancel` latches |a|, |b|, `qneg = signed_div & (a[W-1]^b[W-1])` and `rneg = signed_div & a[W-1]`, clears the partial remainder, sets counter=0 and moves to BUSY.
  - If `b==0`, move to DONE instead, with quotient = all ones and remainder = `a`. These are defined values; MIPS leaves this case unpredictable.
- BUSY, each cycle:
  - Shift {rem, quo} left by 1 and trial-subtract |b| from the upper WIDTH+1 bits.
  - If the difference is non-negative, keep it and set the quotient LSB to 1. Otherwise restore and set it to 0.
  - Increment the counter. After iteration WIDTH, apply sign fixups and move to DONE.
- Sign fixup: the quotient is negated if `qneg`, the remainder if `rneg`. Arithmetic is mod 2^WIDTH, so 0x80000000 / -1 gives quotient 0x80000000 and remainder 0.
- DONE:
  - `done`=1 and `result` is stable.
  - If `stall_hold` is high, stay in DONE.
  - Otherwise return to IDLE next cycle with `done`=0. E advanced this cycle, so the new E instruction starts fresh.
- `cancel`, in any state, returns the block to IDLE next cycle and wins over `start` in the same cycle. `done` never asserts for a cancelled divide.
- `result` holds its last value until the next accepted start. Its value is only meaningful while `done`=1.
- Operands are never re-sampled while BUSY. Changes on `a`/`b` after acceptance are ignored.
- `rst` mid-operation aborts immediately. The block behaves exactly as after reset.

## Timing
- `start` is sampled high in IDLE in cycle T:
  - Nonzero divisor: `done`=1 in cycle T+WIDTH+1 (T+33 for WIDTH=32), so the hazard unit sees `divstall` for WIDTH+1 cycles.
  - Zero divisor: `done`=1 in cycle T+1.
- `done` is a registered output with no combinational path from any input.
- `stall_hold` does not pause iteration in BUSY. It only extends DONE.
- Back-to-back divides: `start` is high in the cycle after DONE exits, and the block accepts it in IDLE that same cycle. There is one idle cycle between operations, which costs no extra stall beyond the new `divstall`.

## Structure
- Shared package holds:
  - The state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - `DIV_CYCLES` = `WIDTH`.
  - The divide-by-zero result constants.
- Sub-module `div_iter`: combinational single restoring step. It takes the WIDTH+1-bit partial remainder, the quotient and the divisor, and returns the next remainder and quotient.
- The top level contains the FSM, counter, operand/sign registers and fixup.

## Test plan
- Unsigned: `a`=100, `b`=7, `signed_div`=0 → `done` at T+33 with quotient 14, remainder 2. `done` falls the cycle after, with `stall_hold`=0.
- Signed: `a`=-7 (0xFFFFFFF9), `b`=2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). The case 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divide by zero: `a`=0x1234, `b`=0 → `done` at T+1 with quotient 0xFFFFFFFF, remainder 0x1234.
- Cancel: assert `cancel` at T+10 → IDLE at T+11, `done` never rises. Next `start` with 9/3 → quotient 3, remainder 0.
- Stall hold: `stall_hold` high from T+30 to T+40 → `done`=1 and `result` stable for T+33..T+40, IDLE at T+41. A back-to-back `start` is accepted at T+41 and finishes at T+74.
- Reset: `rst` pulsed at T+5 of a divide → `done`=0, `result`=0, IDLE next cycle, no stale completion.

Source files
------------

// File: rtl/div_radix2_pkg.sv
// div_radix2_pkg: shared state encoding and constants for the radix-2 divider
package div_radix2_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int DEF_WIDTH = 32;
    localparam int DIV_CYCLES = DEF_WIDTH;
    localparam logic DIVZ_QUO_BIT = 1'b1;
endpackage

// File: rtl/div_radix2_if.sv
// div_radix2_if: start/done handshake and operand/result bus of the divider
interface div_radix2_if #(parameter int WIDTH = 32);
    logic start;
    logic signed_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic cancel;
    logic stall_hold;
    logic done;
    logic [2*WIDTH-1:0] result;
    modport master (output start, signed_div, a, b, cancel, stall_hold, input done, result);
    modport slave (input start, signed_div, a, b, cancel, stall_hold, output done, result);
endinterface

// File: rtl/div_radix2_iter.sv
// div_iter: one combinational restoring-division step
module div_iter #(parameter int WIDTH = 32) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   rem_n,
    output logic [WIDTH-1:0] quo_n
);
    logic [WIDTH+1:0] sh;
    logic [WIDTH:0]   diff;
    logic             neg;
    // shift the next dividend bit in, trial-subtract, restore on borrow
    always_comb begin
        sh    = {rem, quo[WIDTH-1]};
        neg   = sh < {2'b0, dvs};
        diff  = sh[WIDTH:0] - {1'b0, dvs};
        rem_n = neg ? sh[WIDTH:0] : diff;
        quo_n = {quo[WIDTH-2:0], ~neg};
    end
endmodule

// File: rtl/div_radix2.sv
// div_radix2: multi-cycle signed/unsigned restoring divider with stall/flush handshake
module div_radix2 import div_radix2_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
    input logic clk,
    input logic rst,
    div_radix2_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t state, state_n;
    logic [WIDTH:0]     rem, rem_n;
    logic [WIDTH-1:0]   quo, quo_n, dvs, abs_a, abs_b, fix_rem, fix_quo;
    logic               qneg, rneg, accept, last, zero;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] res;

    assign abs_a   = bus.signed_div & bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign abs_b   = bus.signed_div & bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign zero    = bus.b == '0;
    assign accept  = (state == IDLE) & bus.start & ~bus.cancel;
    assign last    = cnt == CW'(WIDTH - 1);
    assign fix_rem = rneg ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];
    assign fix_quo = qneg ? -quo_n : quo_n;
    assign bus.done   = state == DONE;
    assign bus.result = res;

    div_iter #(.WIDTH(WIDTH)) u_iter (
        .rem   (rem),
        .quo   (quo),
        .dvs   (dvs),
        .rem_n (rem_n),
        .quo_n (quo_n)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state: cancel wins everywhere, stall_hold only extends DONE
    always_comb begin
        state_n = state;
        state_n = bus.cancel      ? IDLE :
                  state == IDLE   ? (bus.start ? (zero ? DONE : BUSY) : IDLE) :
                  state == BUSY   ? (last ? DONE : BUSY) :
                  bus.stall_hold  ? DONE : IDLE;
    end

    // operand capture, iteration and result write-back with sign fixup
    always_ff @(posedge clk) begin
        if (rst) begin
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
            qneg <= 1'b0;
            rneg <= 1'b0;
            cnt  <= '0;
            res  <= '0;
        end else if (accept) begin
            rem  <= '0;
            quo  <= abs_a;
            dvs  <= abs_b;
            qneg <= bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            rneg <= bus.signed_div & bus.a[WIDTH-1];
            cnt  <= '0;
            if (zero) res <= {bus.a, {WIDTH{DIVZ_QUO_BIT}}};
        end else if (state == BUSY && !bus.cancel) begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt + 1'b1;
            if (last) res <= {fix_rem, fix_quo};
        end
    end
endmodule

// File: tb/tb_div_radix2.sv
// tb_div_radix2: directed scoreboard bench for the radix-2 divider
module tb_div_radix2;
    import div_radix2_pkg::*;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail = 0;
    logic [2*W-1:0] sb[$];

    div_radix2_if #(.WIDTH(W)) bus ();
    div_radix2 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // reference: divide magnitudes, then apply signs; b==0 gives all-ones/dividend
    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W-1:0] ux, uy, q, r;
        if (y == '0) return {x, {W{1'b1}}};
        ux = (s && x[W-1]) ? -x : x;
        uy = (s && y[W-1]) ? -y : y;
        q = ux / uy;
        r = ux % uy;
        if (s && (x[W-1] ^ y[W-1])) q = -q;
        if (s && x[W-1]) r = -r;
        return {r, q};
    endfunction

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        bus.a = x;
        bus.b = y;
        bus.signed_div = s;
        bus.start = 1'b1;
        sb.push_back(model(x, y, s));
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat = 0;
        logic [2*W-1:0] exp;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 2) begin
                bus.a = $urandom;
                bus.b = $urandom;
            end
        end while (!bus.done && lat < 100);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        exp = sb.pop_front();
        check({tag, "_res"}, bus.result, exp);
        bus.start = 1'b0;
        @(negedge clk);
        check({tag, "_fall"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [2*W-1:0] held;
        logic seen;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.signed_div = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cancel = 1'b0;
        bus.stall_hold = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", bus.result, 64'd0);

        issue(32'd100, 32'd7, 1'b0);
        wait_done("udiv", DIV_CYCLES + 1);
        issue(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done("sdiv", DIV_CYCLES + 1);
        check("sdiv_lit", model(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done("ovf", DIV_CYCLES + 1);
        issue(32'h1234, 32'd0, 1'b0);
        wait_done("divz", 1);
        issue(32'h8765_4321, 32'd0, 1'b1);
        wait_done("divz_s", 1);
        for (int i = 0; i < 4; i++) begin
            issue($urandom, (i == 3) ? 32'hFFFF_FFFF : 32'($urandom_range(1, 1000)) ^ {i[0], 31'd0}, i[1]);
            wait_done("rand", DIV_CYCLES + 1);
        end

        issue(32'd500, 32'd3, 1'b0);
        repeat (10) @(negedge clk);
        bus.cancel = 1'b1;
        repeat (2) @(negedge clk);
        bus.cancel = 1'b0;
        bus.start = 1'b0;
        void'(sb.pop_back());
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen = seen | bus.done;
        end
        check("cancel_nodone", 64'(seen), 64'd0);
        issue(32'd9, 32'd3, 1'b0);
        wait_done("after_cancel", DIV_CYCLES + 1);

        issue(32'hFFFF_FF9C, 32'd7, 1'b1);
        repeat (30) @(negedge clk);
        bus.stall_hold = 1'b1;
        repeat (3) @(negedge clk);
        check("hold_done33", 64'(bus.done), 64'd1);
        held = sb.pop_front();
        check("hold_res", bus.result, held);
        for (int i = 34; i <= 40; i++) begin
            @(negedge clk);
            check("hold_stable", {bus.result[2*W-1:1], bus.done}, {held[2*W-1:1], 1'b1});
            check("hold_lsb", 64'(bus.result[0]), 64'(held[0]));
        end
        bus.stall_hold = 1'b0;
        @(negedge clk);
        check("hold_idle41", 64'(bus.done), 64'd0);
        issue(32'd1000, 32'd33, 1'b0);
        wait_done("b2b", DIV_CYCLES + 1);

        issue(32'd77, 32'd5, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        check("mrst_done", 64'(bus.done), 64'd0);
        check("mrst_result", bus.result, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen = seen | bus.done;
        end
        check("mrst_nostale", 64'(seen), 64'd0);
        issue(32'hFFFF_FFF0, 32'hFFFF_FFFD, 1'b1);
        wait_done("post_rst", DIV_CYCLES + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
